// File: rtl/pipe_skid_reg.sv
// pipe_skid_reg
// Elastic pipeline stage register with a one-entry skid buffer. The main
// register drives out_data. The skid register catches the single payload
// that can arrive in the cycle after the downstream stalls. Because of this,
// in_ready comes straight from a flop and never depends on out_ready.
//
// Ports:
//   clk       - rising-edge clock
//   reset     - synchronous active-high reset (highest priority)
//   flush     - synchronous active-high discard of all entries
//   in_valid  - upstream payload present
//   in_ready  - registered; a payload can be accepted this cycle
//   in_data   - upstream payload (WIDTH bits)
//   out_valid - registered; out_data holds a valid payload
//   out_ready - downstream accepts this cycle
//   out_data  - registered; always the main register
//   count     - registered occupancy, 0..2
module pipe_skid_reg #(
  parameter int unsigned WIDTH        = 32,
  parameter bit          CLR_ON_FLUSH = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       count
);

  // The state encoding equals the occupancy, so count is a copy of the state.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_BUSY  = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t           state_q, state_d, hs_state_s;
  logic [WIDTH-1:0] main_q, main_d, hs_main_s;
  logic [WIDTH-1:0] skid_q, skid_d, hs_skid_s;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic [1:0]       count_q, count_d;
  logic             in_fire_s, out_fire_s;

  // Both handshakes are qualified only by registered flags, so no input
  // reaches any output without passing through a flop.
  assign in_fire_s  = in_valid & in_ready_q;
  assign out_fire_s = out_valid_q & out_ready;

  // Handshake-driven next state and data movement, with flush and reset ignored.
  always_comb begin
    hs_state_s = state_q;
    hs_main_s  = main_q;
    hs_skid_s  = skid_q;
    case (state_q)
      ST_EMPTY: begin
        if (in_fire_s) begin
          hs_state_s = ST_BUSY;
          hs_main_s  = in_data;
        end else begin
          hs_state_s = ST_EMPTY;
        end
      end
      ST_BUSY: begin
        if (in_fire_s && out_fire_s) begin
          hs_main_s = in_data;
        end else if (in_fire_s) begin
          // The main register is occupied and not draining, so the new payload goes to skid.
          hs_state_s = ST_FULL;
          hs_skid_s  = in_data;
        end else if (out_fire_s) begin
          hs_state_s = ST_EMPTY;
        end else begin
          hs_state_s = ST_BUSY;
        end
      end
      ST_FULL: begin
        // in_ready is low while FULL, so the only possible move is skid to main.
        if (out_fire_s) begin
          hs_state_s = ST_BUSY;
          hs_main_s  = skid_q;
        end else begin
          hs_state_s = ST_FULL;
        end
      end
      default: begin
        hs_state_s = ST_EMPTY;
      end
    endcase
  end

  // Apply flush over the handshake result and derive the registered outputs from the next state.
  always_comb begin
    state_d = hs_state_s;
    main_d  = hs_main_s;
    skid_d  = hs_skid_s;
    if (flush) begin
      // A payload offered in this cycle is dropped. An output fire in this
      // cycle has already completed on the downstream side.
      state_d = ST_EMPTY;
      if (CLR_ON_FLUSH) begin
        main_d = {WIDTH{1'b0}};
        skid_d = {WIDTH{1'b0}};
      end else begin
        main_d = main_q;
        skid_d = skid_q;
      end
    end else begin
      state_d = hs_state_s;
    end
    out_valid_d = (state_d != ST_EMPTY);
    in_ready_d  = (state_d != ST_FULL);
    count_d     = state_d;
  end

  // State and data registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_EMPTY;
      main_q      <= {WIDTH{1'b0}};
      skid_q      <= {WIDTH{1'b0}};
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      count_q     <= 2'd0;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      count_q     <= count_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = main_q;
  assign count     = count_q;

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Testbench for pipe_skid_reg. Two instances receive identical stimulus: one
// clears its data on flush and one does not. A queue models the stage
// contents. Each accepted payload is pushed into the queue, and a negedge
// monitor compares the outputs of both instances against the queue.
module tb_pipe_skid_reg;

  logic        clk;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic [31:0] in_data;
  logic        out_ready;
  logic        in_ready0, out_valid0, in_ready1, out_valid1;
  logic [31:0] out_data0, out_data1;
  logic [1:0]  count0, count1;

  int errors;
  int checks;
  logic [31:0] sb_q[$];
  bit started;

  pipe_skid_reg #(.WIDTH(32), .CLR_ON_FLUSH(1'b1)) u_dut_clr (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready0), .in_data(in_data),
    .out_valid(out_valid0), .out_ready(out_ready), .out_data(out_data0),
    .count(count0)
  );

  pipe_skid_reg #(.WIDTH(32), .CLR_ON_FLUSH(1'b0)) u_dut_hold (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready1), .in_data(in_data),
    .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1),
    .count(count1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model update: handshakes are judged from the model's own occupancy.
  always @(posedge clk) begin
    bit ofire, ifire;
    if (reset) begin
      sb_q.delete();
      started = 1'b1;
    end else if (started) begin
      ofire = (sb_q.size() > 0) && out_ready;
      ifire = in_valid && (sb_q.size() < 2);
      if (flush) begin
        sb_q.delete();
      end else begin
        if (ofire) void'(sb_q.pop_front());
        if (ifire) sb_q.push_back(in_data);
      end
    end
  end

  // Monitor: compare both instances against the model, away from the active edge.
  always @(negedge clk) begin
    if (started) begin
      chk("count0", {62'd0, count0}, 64'(sb_q.size()));
      chk("count1", {62'd0, count1}, 64'(sb_q.size()));
      chk("out_valid0", {63'd0, out_valid0}, {63'd0, sb_q.size() > 0});
      chk("out_valid1", {63'd0, out_valid1}, {63'd0, sb_q.size() > 0});
      chk("in_ready0", {63'd0, in_ready0}, {63'd0, sb_q.size() < 2});
      chk("in_ready1", {63'd0, in_ready1}, {63'd0, sb_q.size() < 2});
      if (sb_q.size() > 0) begin
        chk("out_data0", {32'd0, out_data0}, {32'd0, sb_q[0]});
        chk("out_data1", {32'd0, out_data1}, {32'd0, sb_q[0]});
      end
    end
  end

  // Drive one cycle of inputs. The call returns 2 time units after the rising edge.
  task automatic cyc(input logic iv, input logic [31:0] d, input logic ordy,
                     input logic fl, input logic rs);
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
    reset     = rs;
    @(posedge clk);
    #2;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    started = 1'b0;
    in_valid = 1'b0; in_data = 32'd0; out_ready = 1'b0; flush = 1'b0; reset = 1'b0;

    // Reset held for 2 cycles while a payload is offered.
    cyc(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b1);
    chk("rst_out_data0", {32'd0, out_data0}, 64'd0);
    chk("rst_out_data1", {32'd0, out_data1}, 64'd0);
    chk("rst_in_ready", {63'd0, in_ready0}, 64'd1);

    // The first payload after release appears after 1 cycle.
    cyc(1'b1, 32'h0000_0011, 1'b0, 1'b0, 1'b0);
    chk("first_valid", {63'd0, out_valid0}, 64'd1);
    chk("first_data", {32'd0, out_data0}, 64'h11);
    cyc(1'b0, 32'd0, 1'b1, 1'b0, 1'b0);

    // Streaming 1..4 with out_ready held high.
    for (int i = 1; i <= 4; i++) begin
      cyc(1'b1, 32'(i), 1'b1, 1'b0, 1'b0);
      chk("stream_data", {32'd0, out_data0}, 64'(i));
      chk("stream_count", {62'd0, count0}, 64'd1);
    end
    cyc(1'b0, 32'd0, 1'b1, 1'b0, 1'b0);

    // Stall and skid: push A; out_ready falls as B is pushed; C waits upstream.
    cyc(1'b1, 32'h0000_00A0, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 32'h0000_00B0, 1'b0, 1'b0, 1'b0);
    chk("skid_count", {62'd0, count0}, 64'd2);
    chk("skid_in_ready", {63'd0, in_ready0}, 64'd0);
    cyc(1'b1, 32'h0000_00C0, 1'b0, 1'b0, 1'b0);
    chk("skid_hold_a", {32'd0, out_data0}, 64'hA0);
    cyc(1'b1, 32'h0000_00C0, 1'b1, 1'b0, 1'b0);  // A leaves; B moves to main
    chk("unstall_b", {32'd0, out_data0}, 64'hB0);
    cyc(1'b1, 32'h0000_00C0, 1'b1, 1'b0, 1'b0);  // B leaves; C is accepted
    chk("unstall_c", {32'd0, out_data0}, 64'hC0);
    cyc(1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
    chk("drained", {62'd0, count0}, 64'd0);

    // Flush while FULL with A/B, with C offered in the flush cycle.
    cyc(1'b1, 32'h0000_0A0A, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 32'h0000_0B0B, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 32'h0000_0C0C, 1'b0, 1'b1, 1'b0);
    chk("flush_count", {62'd0, count0}, 64'd0);
    chk("flush_clr_data", {32'd0, out_data0}, 64'd0);
    chk("flush_hold_data", {32'd0, out_data1}, 64'hA0A);
    chk("flush_hold_valid", {63'd0, out_valid1}, 64'd0);
    cyc(1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
    chk("flush_no_c", {63'd0, out_valid0}, 64'd0);

    // Reset and flush together in BUSY, then X offered under flush.
    cyc(1'b1, 32'h0000_1234, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 32'd0, 1'b0, 1'b1, 1'b1);
    chk("rstfl_data0", {32'd0, out_data0}, 64'd0);
    chk("rstfl_data1", {32'd0, out_data1}, 64'd0);
    chk("rstfl_ready", {63'd0, in_ready1}, 64'd1);
    cyc(1'b1, 32'h0000_5678, 1'b1, 1'b1, 1'b0);
    chk("x_dropped", {63'd0, out_valid0}, 64'd0);

    // Random traffic with occasional flush; the scoreboard checks every cycle.
    for (int i = 0; i < 3000; i++) begin
      cyc(1'($urandom_range(0, 1)), $urandom(), 1'($urandom_range(0, 1)),
          ($urandom_range(0, 63) == 0), 1'b0);
    end
    cyc(1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
    chk("final_empty", {62'd0, count0}, 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
